tlp_vc_arbiter: RTL and testbench

- Round-robin scheduler that shares one TLP egress link among four virtual-channel FIFOs (VC0..VC3).
- Pops words from the selected source FIFO and presents them as a single stream tagged with the VC index.
- Honours the per-VC pause vector and the halt/idle status produced by the FIFO flow-control FSM.
- Bounds each grant to a configurable burst length.

---
 rtl/tlp_vc_arbiter_pkg.sv | 28 ++
 rtl/tlp_vc_arbiter_rr_pick4.sv | 27 ++
 rtl/tlp_vc_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_tlp_vc_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_vc_arbiter_pkg.sv
// Shared definitions for the TLP virtual-channel arbiter.
// VC count, index width, FSM state and VC index constants.
package tlp_vc_arbiter_pkg;

  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } arb_st_e;

  localparam logic [VC_W-1:0] VC0 = 2'd0;
  localparam logic [VC_W-1:0] VC1 = 2'd1;
  localparam logic [VC_W-1:0] VC2 = 2'd2;
  localparam logic [VC_W-1:0] VC3 = 2'd3;

  // One-hot strobe for a VC index.
  function automatic logic [NUM_VC-1:0] vc_onehot(
    input logic [VC_W-1:0] idx
  );
    logic [NUM_VC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tlp_vc_arbiter_rr_pick4.sv
// Combinational 4-way round-robin finder (module rr_pick4).
// Returns the first set req bit searching upward from start, with wrap.
module rr_pick4
  import tlp_vc_arbiter_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  logic [VC_W-1:0]   start,
  output logic              found,
  output logic [VC_W-1:0]   idx
);

  logic [VC_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    found  = |req;
    idx    = start;
    w_cand = start;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      w_cand = start + VC_W'(k);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/tlp_vc_arbiter.sv
// Round-robin burst scheduler of four VC FIFOs onto one TLP egress.
// Optional per-VC word counters when VCARB_STATS_EN is defined.
module tlp_vc_arbiter
  import tlp_vc_arbiter_pkg::*;
#(
  parameter int DW    = 10,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 halt,
  input  logic [NUM_VC-1:0]    fifo_empty,
  input  logic [NUM_VC-1:0]    pause,
  input  logic [NUM_VC*DW-1:0] data_in,
  output logic [NUM_VC-1:0]    pop,
  output logic                 valid_out,
  output logic [DW-1:0]        data_out,
  output logic [VC_W-1:0]      vc_out,
  output logic                 idle
`ifdef VCARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [NUM_VC*16-1:0] word_cnt
`endif
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  arb_st_e           r_st;
  logic [VC_W-1:0]   r_grant;
  logic [VC_W-1:0]   r_last;
  logic [3:0]        r_burst_cnt;
  logic              r_valid_out;
  logic [VC_W-1:0]   r_vc_out;

  logic [NUM_VC-1:0] w_elig;
  logic [VC_W-1:0]   w_start;
  logic              w_found;
  logic [VC_W-1:0]   w_pick;
  logic              w_cont;
  logic [VC_W-1:0]   w_pop_idx;
  logic              w_any_pop;

  // Eligibility; reset forces everything ineligible so pop settles low.
  always_comb begin
    w_elig = {NUM_VC{enable & ~halt & ~reset}}
           & ~fifo_empty & ~pause;
  end

  // Search origin: after last served VC when idle, after grant when serving.
  always_comb begin
    w_start = (r_st == ST_IDLE) ? (r_last + 2'd1)
                                : (r_grant + 2'd1);
  end

  rr_pick4 u_pick (
    .req   (w_elig),
    .start (w_start),
    .found (w_found),
    .idx   (w_pick)
  );

  // Keep popping the granted VC while eligible and under the burst cap.
  always_comb begin
    w_cont = (r_st == ST_SERVE)
           && w_elig[r_grant]
           && (r_burst_cnt < BURST_L);
  end

  // Mealy pop strobe: continue current grant or start a fresh pick.
  always_comb begin
    pop       = '0;
    w_pop_idx = w_pick;
    w_any_pop = 1'b0;
    if (w_cont) begin
      pop       = vc_onehot(r_grant);
      w_pop_idx = r_grant;
      w_any_pop = 1'b1;
    end else if (w_found) begin
      pop       = vc_onehot(w_pick);
      w_pop_idx = w_pick;
      w_any_pop = 1'b1;
    end
  end

  // Grant FSM with zero-bubble rotation and saturating burst count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st        <= ST_IDLE;
      r_grant     <= VC0;
      r_last      <= VC3;
      r_burst_cnt <= 4'd0;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          if (w_found) begin
            r_st        <= ST_SERVE;
            r_grant     <= w_pick;
            r_burst_cnt <= 4'd1;
          end
        end
        ST_SERVE: begin
          if (w_cont) begin
            if (r_burst_cnt != 4'hF) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
            end
          end else if (w_found) begin
            r_last      <= r_grant;
            r_grant     <= w_pick;
            r_burst_cnt <= 4'd1;
          end else begin
            r_st   <= ST_IDLE;
            r_last <= r_grant;
          end
        end
        default: begin
          r_st <= ST_IDLE;
        end
      endcase
    end
  end

  // Output stage: tag arrives with the word one cycle after the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_out <= 1'b0;
      r_vc_out    <= VC0;
    end else begin
      r_valid_out <= w_any_pop;
      if (w_any_pop) begin
        r_vc_out <= w_pop_idx;
      end
    end
  end

  // Word mux driven by the registered VC select.
  always_comb begin
    data_out = data_in[DW-1:0];
    unique case (r_vc_out)
      VC0: data_out = data_in[0*DW +: DW];
      VC1: data_out = data_in[1*DW +: DW];
      VC2: data_out = data_in[2*DW +: DW];
      VC3: data_out = data_in[3*DW +: DW];
      default: data_out = data_in[DW-1:0];
    endcase
  end

  assign valid_out = r_valid_out;
  assign vc_out    = r_vc_out;
  assign idle      = ~|w_elig;

`ifdef VCARB_STATS_EN
  logic [15:0] r_word_cnt [NUM_VC];

  // Per-VC delivered word counters; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) begin
        r_word_cnt[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (stats_clr) begin
          r_word_cnt[i] <= 16'h0;
        end else if (r_valid_out
                     && (r_vc_out == VC_W'(i))
                     && (r_word_cnt[i] != 16'hFFFF)) begin
          r_word_cnt[i] <= r_word_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      word_cnt[i*16 +: 16] = r_word_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_tlp_vc_arbiter.sv
// Directed self-checking bench for tlp_vc_arbiter (DW=10, BURST=4).
// Inputs change on falling edges; outputs are checked 1 ns later.
module tb_tlp_vc_arbiter;

  localparam int DW = 10;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          halt;
  logic [3:0]    fifo_empty;
  logic [3:0]    pause;
  logic [4*DW-1:0] data_in;
  logic [3:0]    pop;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [1:0]    vc_out;
  logic          idle;
`ifdef VCARB_STATS_EN
  logic          stats_clr;
  logic [63:0]   word_cnt;
`endif

  int n_checks;
  int n_fail;

  tlp_vc_arbiter #(.DW(DW), .BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .halt       (halt),
    .fifo_empty (fifo_empty),
    .pause      (pause),
    .data_in    (data_in),
    .pop        (pop),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .vc_out     (vc_out),
    .idle       (idle)
`ifdef VCARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .word_cnt   (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] vcdata(input int vc);
    return DW'(10'h0C0 + vc * 10'h101);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    fifo_empty = 4'hF;
    pause      = 4'h0;
    halt       = 1'b0;
    enable     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset      = 1'b1;
    fifo_empty = 4'hF;
    enable     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) reset = 1'b0;
      #1;
      n_checks++;
      if (pop !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_pop k=%0d got=%h exp=0", k, pop);
      end
      n_checks++;
      if (idle !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%b exp=1", k, idle);
      end
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid k=%0d got=%b exp=0", k, valid_out);
      end
      n_checks++;
      if (data_out !== vcdata(0)) begin
        n_fail++;
        $display("FAIL reset_data k=%0d got=%h exp=%h",
                 k, data_out, vcdata(0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int vc;
    logic [3:0] ep;
    do_reset();
    fifo_empty = 4'h0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      ep = 4'(1 << ((k / 4) % 4));
      n_checks++;
      if (pop !== ep) begin
        n_fail++;
        $display("FAIL rr_pop k=%0d got=%b exp=%b", k, pop, ep);
      end
      if (k >= 1) begin
        vc = ((k - 1) / 4) % 4;
        n_checks++;
        if (valid_out !== 1'b1 || vc_out !== 2'(vc)) begin
          n_fail++;
          $display("FAIL rr_out k=%0d valid=%b vc=%0d exp_vc=%0d",
                   k, valid_out, vc_out, vc);
        end
        n_checks++;
        if (data_out !== vcdata(vc)) begin
          n_fail++;
          $display("FAIL rr_data k=%0d got=%h exp=%h",
                   k, data_out, vcdata(vc));
        end
      end
    end
  endtask

  task automatic test_single_vc();
    do_reset();
    fifo_empty = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++;
      if (pop !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_pop k=%0d got=%b exp=0100", k, pop);
      end
      if (k >= 1) begin
        n_checks++;
        if (valid_out !== 1'b1 || vc_out !== 2'd2) begin
          n_fail++;
          $display("FAIL single_out k=%0d valid=%b vc=%0d exp_vc=2",
                   k, valid_out, vc_out);
        end
      end
    end
  endtask

  task automatic test_pause();
    int exp_idx [15];
    exp_idx = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    do_reset();
    fifo_empty = 4'h0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) pause = 4'b0001;
      if (k == 6) pause = 4'b0000;
      #1;
      n_checks++;
      if (pop !== 4'(1 << exp_idx[k])) begin
        n_fail++;
        $display("FAIL pause_pop k=%0d got=%b exp_vc=%0d",
                 k, pop, exp_idx[k]);
      end
      if (k == 3) begin
        n_checks++;
        if (valid_out !== 1'b1 || vc_out !== 2'd1) begin
          n_fail++;
          $display("FAIL pause_vc k=3 valid=%b vc=%0d exp_vc=1",
                   valid_out, vc_out);
        end
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    fifo_empty = 4'h0;
    #1;
    n_checks++;
    if (pop !== 4'b0001) begin
      n_fail++;
      $display("FAIL halt_k0 got=%b exp=0001", pop);
    end
    @(negedge clk);
    #1;
    @(negedge clk);
    halt = 1'b1;
    #1;
    n_checks++;
    if (pop !== 4'h0 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_pop got=%b idle=%b exp=0000 idle=1", pop, idle);
    end
    n_checks++;
    if (valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_prev_valid got=%b exp=1", valid_out);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || pop !== 4'h0) begin
      n_fail++;
      $display("FAIL halt_valid got=%b pop=%b exp=0 0000", valid_out, pop);
    end
    @(negedge clk);
    halt = 1'b0;
    #1;
    n_checks++;
    if (pop !== 4'b0010) begin
      n_fail++;
      $display("FAIL halt_resume got=%b exp=0010", pop);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b1 || vc_out !== 2'd1) begin
      n_fail++;
      $display("FAIL halt_resume_out valid=%b vc=%0d exp_vc=1",
               valid_out, vc_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fifo_empty = 4'h0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
    end
    n_checks++;
    if (pop !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmid_pre got=%b exp=0010", pop);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || pop !== 4'h0 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_async valid=%b pop=%b idle=%b exp=0 0000 1",
               valid_out, pop, idle);
    end
    n_checks++;
    if (vc_out !== 2'd0) begin
      n_fail++;
      $display("FAIL rmid_vc got=%0d exp=0", vc_out);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (pop !== 4'b0001 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_first pop=%b valid=%b exp=0001 0", pop, valid_out);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b1 || vc_out !== 2'd0) begin
      n_fail++;
      $display("FAIL rmid_out valid=%b vc=%0d exp_vc=0", valid_out, vc_out);
    end
  endtask

`ifdef VCARB_STATS_EN
  task automatic test_stats();
    do_reset();
    fifo_empty = 4'b0111;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 10) fifo_empty = 4'hF;
      #1;
    end
    n_checks++;
    if (word_cnt[63:48] !== 16'd10 || word_cnt[47:0] !== 48'd0) begin
      n_fail++;
      $display("FAIL stats_cnt got=%h exp=000a000000000000", word_cnt);
    end
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    n_checks++;
    if (word_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL stats_clr got=%h exp=0", word_cnt);
    end
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    halt       = 1'b0;
    fifo_empty = 4'hF;
    pause      = 4'h0;
    data_in    = {vcdata(3), vcdata(2), vcdata(1), vcdata(0)};
`ifdef VCARB_STATS_EN
    stats_clr  = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_single_vc();
    test_pause();
    test_halt();
    test_reset_mid();
`ifdef VCARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
